// File: rtl/wb_lsu_master_pkg.sv
// Shared types for the Wishbone load/store master: access sizes, FSM states
// and the width of the bus-cycle timeout counter.
package lsu_pkg;

   typedef enum logic [1:0] {
      LSU_BYTE = 2'b00,
      LSU_HALF = 2'b01,
      LSU_WORD = 2'b10
   } lsu_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUS  = 2'b01,
      RESP = 2'b10
   } lsu_state_e;

   localparam int CNT_W = 16;

endpackage

// File: rtl/wb_lsu_master_if.sv
// Core request/response and Wishbone classic signals of the load/store master.
// The master modport is the LSU view; the slave modport is its environment.
interface wb_lsu_master_if;

   logic        req_i;
   logic        we_i;
   logic [1:0]  size_i;
   logic        unsigned_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        gnt_o;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_adr_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        wb_err_i;

   modport master (
      input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
      input  wb_dat_i, wb_ack_i, wb_err_i,
      output gnt_o, rvalid_o, rdata_o, err_o,
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o
   );

   modport slave (
      output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
      output wb_dat_i, wb_ack_i, wb_err_i,
      input  gnt_o, rvalid_o, rdata_o, err_o,
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o
   );

endinterface

// File: rtl/wb_lsu_master_data_align.sv
// Combinational byte-lane logic: select generation, store-data replication
// and load-data extraction with sign or zero extension.
module lsu_data_align
   import lsu_pkg::*;
(
   input  logic [1:0]  i_reqSize,
   input  logic [1:0]  i_reqOff,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_ldSize,
   input  logic [1:0]  i_ldOff,
   input  logic        i_ldUnsigned,
   input  logic [31:0] i_busData,
   output logic [3:0]  o_sel,
   output logic [31:0] o_wdat,
   output logic [31:0] o_ldata
);

   function automatic logic [3:0] genSel(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] sel;
      case (size)
         LSU_BYTE: sel = 4'b0001 << off;
         LSU_HALF: sel = 4'b0011 << off;
         default:  sel = 4'b1111;
      endcase
      return sel;
   endfunction

   function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
      logic [31:0] r;
      case (size)
         LSU_BYTE: r = {4{d[7:0]}};
         LSU_HALF: r = {2{d[15:0]}};
         default:  r = d;
      endcase
      return r;
   endfunction

   // Byte and half lanes are picked from the latched offset of the granted access
   function automatic logic [31:0] extract(input logic [1:0] size, input logic [1:0] off,
                                           input logic uns, input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = d[{off, 3'b000} +: 8];
      h = d[{off[1], 4'b0000} +: 16];
      case (size)
         LSU_BYTE: r = {{24{b[7] & ~uns}}, b};
         LSU_HALF: r = {{16{h[15] & ~uns}}, h};
         default:  r = d;
      endcase
      return r;
   endfunction

   assign o_sel   = genSel(i_reqSize, i_reqOff);
   assign o_wdat  = replicate(i_reqSize, i_wdata);
   assign o_ldata = extract(i_ldSize, i_ldOff, i_ldUnsigned, i_busData);

endmodule

// File: rtl/wb_lsu_master.sv
// Wishbone classic master turning one core load/store into one bus cycle,
// with misalignment detection, bus-error reporting and a cycle timeout.
module wb_lsu_master
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 255
)
(
   input  logic            clk,
   input  logic            rst_i,
   wb_lsu_master_if.master bus
);

   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

   lsu_state_e        r_state;
   lsu_state_e        w_nextState;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_we;
   logic [1:0]        r_size;
   logic              r_unsigned;
   logic [1:0]        r_off;
   logic              r_cyc;
   logic              r_wbWe;
   logic [31:0]       r_adr;
   logic [3:0]        r_sel;
   logic [31:0]       r_dat;
   logic [31:0]       r_rdata;
   logic              r_err;

   logic              w_gnt;
   logic              w_rvalid;
   logic              w_misaligned;
   logic              w_timeout;
   logic              w_busDone;
   logic [3:0]        w_sel;
   logic [31:0]       w_wdat;
   logic [31:0]       w_ldata;

   lsu_data_align u_align (
      .i_reqSize    (bus.size_i),
      .i_reqOff     (bus.addr_i[1:0]),
      .i_wdata      (bus.wdata_i),
      .i_ldSize     (r_size),
      .i_ldOff      (r_off),
      .i_ldUnsigned (r_unsigned),
      .i_busData    (bus.wb_dat_i),
      .o_sel        (w_sel),
      .o_wdat       (w_wdat),
      .o_ldata      (w_ldata)
   );

   always_comb begin
      w_misaligned = 1'b1;
      case (bus.size_i)
         LSU_BYTE: w_misaligned = 1'b0;
         LSU_HALF: w_misaligned = bus.addr_i[0];
         LSU_WORD: w_misaligned = (bus.addr_i[1:0] != 2'b00);
         default:  w_misaligned = 1'b1;
      endcase
   end

   assign w_timeout = (r_cnt == TIMEOUT_LAST);
   assign w_busDone = bus.wb_err_i | bus.wb_ack_i | w_timeout;

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_gnt       = 1'b0;
      w_rvalid    = 1'b0;
      case (r_state)
         IDLE: begin
            w_gnt = bus.req_i;
            if (bus.req_i) begin
               w_nextState = w_misaligned ? RESP : BUS;
            end
         end
         BUS: begin
            if (w_busDone) begin
               w_nextState = RESP;
            end
         end
         RESP: begin
            w_rvalid    = 1'b1;
            w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Err wins over ack, and ack wins over a timeout landing on the same cycle
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         r_cnt      <= '0;
         r_we       <= 1'b0;
         r_size     <= 2'b00;
         r_unsigned <= 1'b0;
         r_off      <= 2'b00;
         r_cyc      <= 1'b0;
         r_wbWe     <= 1'b0;
         r_adr      <= '0;
         r_sel      <= '0;
         r_dat      <= '0;
         r_rdata    <= '0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.req_i) begin
                  r_we       <= bus.we_i;
                  r_size     <= bus.size_i;
                  r_unsigned <= bus.unsigned_i;
                  r_off      <= bus.addr_i[1:0];
                  r_adr      <= {bus.addr_i[31:2], 2'b00};
                  r_cnt      <= '0;
                  r_rdata    <= '0;
                  r_err      <= w_misaligned;
                  if (!w_misaligned) begin
                     r_cyc  <= 1'b1;
                     r_wbWe <= bus.we_i;
                     r_sel  <= w_sel;
                     r_dat  <= w_wdat;
                  end
               end
            end
            BUS: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_busDone) begin
                  r_cyc   <= 1'b0;
                  r_wbWe  <= 1'b0;
                  r_sel   <= '0;
                  r_dat   <= '0;
                  r_err   <= bus.wb_err_i | ~bus.wb_ack_i;
                  r_rdata <= (bus.wb_ack_i && !bus.wb_err_i && !r_we) ? w_ldata : 32'h0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.gnt_o    = w_gnt;
   assign bus.rvalid_o = w_rvalid;
   assign bus.rdata_o  = r_rdata;
   assign bus.err_o    = r_err;
   assign bus.wb_cyc_o = r_cyc;
   assign bus.wb_stb_o = r_cyc;
   assign bus.wb_we_o  = r_wbWe;
   assign bus.wb_adr_o = r_adr;
   assign bus.wb_sel_o = r_sel;
   assign bus.wb_dat_o = r_dat;

endmodule

// File: tb/tb_wb_lsu_master.sv
// Directed bench for wb_lsu_master: a cycle-level expectation model checked
// every negedge, plus literal expectations for the key transactions.
module tb_wb_lsu_master;
   import lsu_pkg::*;

   localparam int TO = 8;

   logic clock;
   logic reset;

   wb_lsu_master_if busIf();

   wb_lsu_master #(.TIMEOUT(TO)) dut (
      .clk   (clock),
      .rst_i (reset),
      .bus   (busIf)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cycleNo = 0;
   int grantCyc = 0;
   int cycCycles = 0;
   int rvalidCount = 0;
   int lastLatency = 0;
   logic [31:0] lastRdata = '0;
   logic        lastErr = 1'b0;
   logic [3:0]  lastSel = '0;
   logic [31:0] lastDat = '0;

   logic        expGnt = 1'b0;
   logic        expCyc = 1'b0;
   logic        expRvalid = 1'b0;
   logic        expErr = 1'b0;
   logic        expWe = 1'b0;
   logic [31:0] expRdata = '0;
   logic [31:0] expAdr = '0;
   logic [31:0] expDat = '0;
   logic [3:0]  expSel = '0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic checkBit(input string name, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
      end
   endtask

   // Model: access legality, lane mask, replicated data and loaded value from byte arithmetic
   function automatic bit modelBad(input logic [1:0] size, input logic [31:0] addr);
      int nbytes;
      if (size == 2'b11) return 1'b1;
      nbytes = 1 << int'(size);
      return (int'(addr[1:0]) % nbytes) != 0;
   endfunction

   function automatic logic [3:0] modelSel(input logic [1:0] size, input logic [31:0] addr);
      int nbytes;
      int off;
      logic [3:0] m;
      nbytes = 1 << int'(size);
      off = int'(addr[1:0]);
      m = '0;
      for (int i = 0; i < 4; i++) begin
         if (i >= off && i < off + nbytes) m[i] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic [31:0] modelDat(input logic [1:0] size, input logic [31:0] wdata);
      int nbytes;
      logic [31:0] r;
      nbytes = 1 << int'(size);
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
      end
      return r;
   endfunction

   function automatic logic [31:0] modelLoad(input logic [1:0] size, input logic [31:0] addr,
                                             input logic uns, input logic [31:0] data);
      int nbytes;
      int off;
      logic [31:0] v;
      logic [31:0] mask;
      nbytes = 1 << int'(size);
      off = int'(addr[1:0]);
      v = data >> (8 * off);
      if (nbytes < 4) begin
         mask = (32'h1 << (8 * nbytes)) - 32'h1;
         v = v & mask;
         if (!uns && v[8*nbytes-1]) v = v | ~mask;
      end
      return v;
   endfunction

   always @(negedge clock) begin
      cycleNo++;
      if (!reset) begin
         checkBit("gnt", busIf.gnt_o, expGnt);
         checkBit("cyc", busIf.wb_cyc_o, expCyc);
         checkBit("stb", busIf.wb_stb_o, expCyc);
         checkBit("rvalid", busIf.rvalid_o, expRvalid);
         if (expCyc) begin
            checkOutput("adr", busIf.wb_adr_o, expAdr);
            checkOutput("sel", {28'h0, busIf.wb_sel_o}, {28'h0, expSel});
            checkOutput("dat", busIf.wb_dat_o, expDat);
            checkBit("we", busIf.wb_we_o, expWe);
         end
         if (expRvalid) begin
            checkOutput("rdata", busIf.rdata_o, expRdata);
            checkBit("err", busIf.err_o, expErr);
         end
         if (busIf.gnt_o) begin
            grantCyc = cycleNo;
            cycCycles = 0;
         end
         if (busIf.wb_cyc_o) begin
            cycCycles++;
            lastSel = busIf.wb_sel_o;
            lastDat = busIf.wb_dat_o;
         end
         if (busIf.rvalid_o) begin
            rvalidCount++;
            lastRdata = busIf.rdata_o;
            lastErr = busIf.err_o;
            lastLatency = cycleNo - grantCyc;
         end
      end
   end

   task automatic scramble();
      busIf.req_i      = 1'b1;
      busIf.we_i       = 1'($urandom);
      busIf.size_i     = 2'($urandom);
      busIf.unsigned_i = 1'($urandom);
      busIf.addr_i     = $urandom;
      busIf.wdata_i    = $urandom;
   endtask

   // One access: grant, then either a bus cycle ended by ack/err/timeout/reset, or an immediate error
   task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdBus, input int ackAt, input int errAt,
                                input int rstAt);
      bit bad;
      bit done;
      bit gotAck;
      bit gotErr;
      int k;
      bad = modelBad(size, addr);
      gotAck = 1'b0;
      gotErr = 1'b0;
      @(posedge clock); #1;
      busIf.req_i      = 1'b1;
      busIf.we_i       = we;
      busIf.size_i     = size;
      busIf.unsigned_i = uns;
      busIf.addr_i     = addr;
      busIf.wdata_i    = wdata;
      busIf.wb_ack_i   = 1'b0;
      busIf.wb_err_i   = 1'b0;
      expGnt = 1'b1;
      expCyc = 1'b0;
      expRvalid = 1'b0;
      @(posedge clock); #1;
      scramble();
      expGnt = 1'b0;
      if (bad) begin
         expRvalid = 1'b1;
         expErr = 1'b1;
         expRdata = '0;
      end else begin
         expCyc = 1'b1;
         expAdr = {addr[31:2], 2'b00};
         expSel = modelSel(size, addr);
         expDat = modelDat(size, wdata);
         expWe = we;
         k = 0;
         done = 1'b0;
         while (!done) begin
            gotAck = (k == ackAt);
            gotErr = (k == errAt);
            busIf.wb_ack_i = gotAck;
            busIf.wb_err_i = gotErr;
            busIf.wb_dat_i = gotAck ? rdBus : $urandom;
            if (k == rstAt) begin
               #2;
               reset = 1'b1;
               #1;
               checkBit("rst_async_cyc", busIf.wb_cyc_o, 1'b0);
               checkBit("rst_async_stb", busIf.wb_stb_o, 1'b0);
               busIf.req_i = 1'b0;
               expCyc = 1'b0;
               repeat (2) @(posedge clock);
               #1;
               reset = 1'b0;
               return;
            end
            done = gotAck || gotErr || (k == TO - 1);
            @(posedge clock); #1;
            k++;
         end
         busIf.wb_ack_i = 1'b0;
         busIf.wb_err_i = 1'b0;
         scramble();
         expCyc = 1'b0;
         expRvalid = 1'b1;
         expErr = gotErr || !gotAck;
         expRdata = (gotAck && !gotErr && !we) ? modelLoad(size, addr, uns, rdBus) : 32'h0;
      end
      @(posedge clock); #1;
      busIf.req_i = 1'b0;
      expRvalid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int savedCount;
      reset = 1'b1;
      busIf.req_i = 1'b0;
      busIf.we_i = 1'b0;
      busIf.size_i = 2'b00;
      busIf.unsigned_i = 1'b0;
      busIf.addr_i = '0;
      busIf.wdata_i = '0;
      busIf.wb_dat_i = '0;
      busIf.wb_ack_i = 1'b0;
      busIf.wb_err_i = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checkBit("reset_cyc", busIf.wb_cyc_o, 1'b0);
      checkBit("reset_rvalid", busIf.rvalid_o, 1'b0);
      checkOutput("reset_rdata", busIf.rdata_o, 32'h0);
      checkOutput("reset_adr", busIf.wb_adr_o, 32'h0);
      reset = 1'b0;

      checkOutput("model_sb", modelLoad(2'b00, 32'h103, 1'b0, 32'h80FF0000), 32'hFFFFFF80);
      checkOutput("model_uh", modelLoad(2'b01, 32'h102, 1'b1, 32'h80FF0000), 32'h000080FF);
      checkOutput("model_bdat", modelDat(2'b00, 32'h000000AB), 32'hABABABAB);
      checkOutput("model_hsel", {28'h0, modelSel(2'b01, 32'h102)}, 32'h0000000C);

      $display("[TB] word store");
      applyStimulus(1'b1, LSU_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 255, 255);
      checkOutput("ws_latency", lastLatency, 2);
      checkOutput("ws_rdata", lastRdata, 32'h0);
      checkBit("ws_err", lastErr, 1'b0);
      checkOutput("ws_sel", {28'h0, lastSel}, 32'hF);

      $display("[TB] byte store with wait states");
      applyStimulus(1'b1, LSU_BYTE, 1'b0, 32'h101, 32'h000000AB, 32'h0, 2, 255, 255);
      checkOutput("bs_sel", {28'h0, lastSel}, 32'h2);
      checkOutput("bs_dat", lastDat, 32'hABABABAB);
      checkOutput("bs_latency", lastLatency, 4);

      $display("[TB] signed byte load");
      applyStimulus(1'b0, LSU_BYTE, 1'b0, 32'h103, 32'h0, 32'h80FF0000, 0, 255, 255);
      checkOutput("sb_rdata", lastRdata, 32'hFFFFFF80);

      $display("[TB] unsigned half load");
      applyStimulus(1'b0, LSU_HALF, 1'b1, 32'h102, 32'h0, 32'h80FF0000, 1, 255, 255);
      checkOutput("uh_rdata", lastRdata, 32'h000080FF);

      $display("[TB] signed half load");
      applyStimulus(1'b0, LSU_HALF, 1'b0, 32'h100, 32'h0, 32'h12348001, 0, 255, 255);
      checkOutput("sh_rdata", lastRdata, 32'hFFFF8001);

      $display("[TB] misaligned word load");
      applyStimulus(1'b0, LSU_WORD, 1'b0, 32'h102, 32'h0, 32'h0, 0, 255, 255);
      checkOutput("mis_latency", lastLatency, 1);
      checkBit("mis_err", lastErr, 1'b1);
      checkOutput("mis_cyc", cycCycles, 0);

      $display("[TB] illegal size and misaligned half");
      applyStimulus(1'b1, 2'b11, 1'b0, 32'h200, 32'h1, 32'h0, 0, 255, 255);
      checkBit("ill_err", lastErr, 1'b1);
      applyStimulus(1'b0, LSU_HALF, 1'b0, 32'h201, 32'h0, 32'h0, 0, 255, 255);
      checkBit("mh_err", lastErr, 1'b1);

      $display("[TB] timeout");
      applyStimulus(1'b0, LSU_WORD, 1'b0, 32'h400, 32'h0, 32'h0, 255, 255, 255);
      checkOutput("to_cyc_cycles", cycCycles, TO);
      checkBit("to_err", lastErr, 1'b1);
      checkOutput("to_latency", lastLatency, TO + 1);

      $display("[TB] ack and err together, then err alone");
      applyStimulus(1'b0, LSU_WORD, 1'b0, 32'h500, 32'h0, 32'h11223344, 1, 1, 255);
      checkBit("ackerr_err", lastErr, 1'b1);
      checkOutput("ackerr_rdata", lastRdata, 32'h0);
      applyStimulus(1'b1, LSU_HALF, 1'b0, 32'h502, 32'h0000BEEF, 32'h0, 255, 0, 255);
      checkBit("err_err", lastErr, 1'b1);

      $display("[TB] stray ack/err while idle");
      savedCount = rvalidCount;
      @(posedge clock); #1;
      busIf.wb_ack_i = 1'b1;
      @(posedge clock); #1;
      busIf.wb_ack_i = 1'b0;
      busIf.wb_err_i = 1'b1;
      @(posedge clock); #1;
      busIf.wb_err_i = 1'b0;
      @(posedge clock); #1;
      checkOutput("stray_rvalids", rvalidCount, savedCount);

      $display("[TB] reset during bus cycle");
      savedCount = rvalidCount;
      applyStimulus(1'b0, LSU_WORD, 1'b0, 32'h300, 32'h0, 32'h0, 255, 255, 2);
      repeat (2) @(posedge clock);
      #1;
      checkOutput("rst_no_rvalid", rvalidCount, savedCount);
      applyStimulus(1'b0, LSU_WORD, 1'b0, 32'h304, 32'h0, 32'hCAFEF00D, 1, 255, 255);
      checkOutput("post_rst_rdata", lastRdata, 32'hCAFEF00D);
      checkOutput("post_rst_latency", lastLatency, 3);

      repeat (2) @(posedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_lsu_master.md
Name: wb_lsu_master

Overview:
- Wishbone classic master that converts core load/store requests into single bus cycles.
- Feeds the RAM wrapper's Wishbone slave port, either directly or through the interconnect.
- Generates byte-lane selects and replicated write data.
- Extracts, sign-extends or zero-extends load data.
- Reports misaligned accesses, bus errors and slave timeouts back to the core.

Parameters:
- TIMEOUT, 255: number of cycles with cyc asserted and no ack/err before the cycle is aborted with an error; legal range 1..65535.

Ports:
- clk  in  1  system clock
- rst_i  in  1  asynchronous reset, active-high
- req_i  in  1  core access request
- we_i  in  1  1 = store, 0 = load
- size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- unsigned_i  in  1  zero-extend loads when 1, sign-extend when 0
- addr_i  in  32  byte address
- wdata_i  in  32  store data, right-aligned
- gnt_o  out  1  request accepted this cycle
- rvalid_o  out  1  response valid, one-cycle pulse
- rdata_o  out  32  load result
- err_o  out  1  response is an error; qualified by rvalid_o
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  Wishbone write enable
- wb_adr_o  out  32  word-aligned address; bits [1:0] always 0
- wb_sel_o  out  4  byte-lane select
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  Wishbone acknowledge
- wb_err_i  in  1  Wishbone error

Behaviour:
- Reset values:
  - Reset is asynchronous; all outputs and state registers are 0.
  - FSM resets to IDLE; timeout counter resets to 0.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - gnt_o = req_i (combinational); gnt_o is 0 in every other state.
  - On grant, latch we, size, unsigned, addr[1:0] and the aligned address.
  - Misaligned or illegal requests (size 11; half with addr[0]=1; word with addr[1:0]≠0) go to RESP with err=1. No bus cycle is issued.
  - Legal requests go to BUS. cyc, stb, we, adr, sel and dat are all registered, so they appear the cycle after the grant.
- Lane generation:
  - sel: byte = 0001<<addr[1:0]; half = 0011<<addr[1:0]; word = 1111.
  - dat: byte = wdata[7:0] replicated 4×; half = wdata[15:0] replicated 2×; word = wdata.
- BUS:
  - cyc, stb and all bus outputs are held stable until termination.
  - The counter increments each BUS cycle.
  - Termination priority: wb_err_i > wb_ack_i > timeout.
  - err: go to RESP with err=1 and rdata=0.
  - ack: go to RESP with err=0. A load captures the extracted data; a store sets rdata=0.
  - timeout (counter = TIMEOUT−1 with no ack/err): go to RESP with err=1.
  - cyc and stb drop on the cycle after termination, i.e. when entering RESP.
- Load extraction:
  - byte = wb_dat_i[8·addr[1:0]+:8]; half = wb_dat_i[16·addr[1]+:16].
  - Sign-extend, or zero-extend when unsigned_i is 1.
- RESP:
  - rvalid_o = 1 for exactly one cycle, with rdata_o and err_o valid.
  - Next state is IDLE. No new grant is given in RESP; the earliest next grant is the following cycle.
- Latency:
  - grant at cycle N → cyc at N+1 → ack at cycle M ≥ N+1 → rvalid at M+1.
  - Misaligned accesses: grant at N → rvalid/err at N+1.
- Stray ack/err:
  - wb_ack_i or wb_err_i outside BUS is ignored.
  - A new request is not granted while a response is pending.
- Reset mid-operation: cyc and stb deassert immediately, the response is discarded (no rvalid), and the FSM returns to IDLE.
- Core contract: inputs are sampled only on the grant cycle; the core may change them afterwards.

Decomposition:
- Shared package (lsu_pkg):
  - size enum: LSU_BYTE, LSU_HALF, LSU_WORD.
  - FSM state enum.
  - TIMEOUT counter width: 16 bits.
- Sub-module lsu_data_align (combinational), three functions:
  - sel generation from size and offset.
  - Write-data replication.
  - Load extraction plus extension.
- The FSM, counter and registers stay in wb_lsu_master.

Test Plan:
- Word store 0xDEADBEEF to 0x100, ack on the first cycle of cyc → adr=0x100, sel=1111, dat=0xDEADBEEF, we=1; rvalid 2 cycles after grant; err=0, rdata=0.
- Byte store 0x000000AB to 0x101 → sel=0010, dat=0xABABABAB.
- Signed byte load at 0x103 with wb_dat_i=0x80FF0000 → rdata=0xFFFFFF80.
- Unsigned half load at 0x102 with the same data → rdata=0x000080FF.
- Word load at 0x102 → rvalid with err=1 one cycle after grant; wb_cyc_o never asserted.
- Error paths:
  - TIMEOUT=8, no ack → cyc high for exactly 8 cycles, then rvalid with err=1.
  - ack and err asserted together → err=1.
- rst_i pulsed 2 cycles into BUS → cyc/stb go low asynchronously, no rvalid, next request granted normally from IDLE.
